// File: rtl/asin_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel arcsine unit:
// FSM states, full-scale constant and the arcsine ROM entry generator.
package asin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        LUT  = 2'd2,
        HOLD = 2'd3
    } asin_state_t;

    function automatic int asin_fs(input int ow);
        return (2 ** (ow - 1)) - 1;
    endfunction

    // Entry a maps a/2^aw to round(asin(x) * FS / (pi/2)); only evaluated at elaboration.
    function automatic int asin_rom_entry(input int a, input int aw, input int ow);
        real x;
        real v;
        x = real'(a) / real'(2 ** aw);
        v = $asin(x) * real'(asin_fs(ow)) / (3.14159265358979323846 / 2.0);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/asin_frac_div.sv
// Restoring fractional divider: q = floor(mag * 2^QW / den), one quotient bit per cycle.
// done is high during the cycle whose closing edge writes the last quotient bit.
module asin_frac_div #(
    parameter int W  = 16,
    parameter int QW = 10
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  mag,
    input  logic [W-1:0]  den,
    output logic          done,
    output logic [QW-1:0] q
);

    localparam int CW = $clog2(QW) + 1;
    localparam logic [CW-1:0] LAST = CW'(QW - 1);

    logic [W:0]    rem;
    logic [W-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic          busy;
    logic [W+1:0]  shifted;
    logic [W:0]    diff;
    logic          ge;
    logic [W:0]    rem_nxt;

    always_comb begin
        shifted = {rem, 1'b0};
        ge      = (shifted >= {2'b00, dvs});
        diff    = shifted[W:0] - {1'b0, dvs};
        rem_nxt = ge ? diff : shifted[W:0];
    end

    assign done = busy && (cnt == LAST);

    always_ff @(posedge clock) begin
        if (rst) begin
            rem  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            q    <= '0;
        end else if (start) begin
            rem  <= {1'b0, mag};
            dvs  <= den;
            cnt  <= '0;
            busy <= 1'b1;
            q    <= '0;
        end else if (busy) begin
            rem <= rem_nxt;
            q   <= {q[QW-2:0], ge};
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/asin_vec_unit.sv
// CH-channel signed arcsine asin(num/den) with valid/ready handshake.
// Define ASIN_ROUND_EN for a rounded ROM address (one extra divider cycle).
module asin_vec_unit
    import asin_pkg::*;
#(
    parameter int W      = 16,
    parameter int OW     = 12,
    parameter int CH     = 2,
    parameter int LUT_AW = 10
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*W-1:0]  in_num,
    input  logic [CH*W-1:0]  in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*OW-1:0] out_angle,
    output logic [CH-1:0]    out_sat
);

`ifdef ASIN_ROUND_EN
    localparam int QW = LUT_AW + 1;
`else
    localparam int QW = LUT_AW;
`endif
    localparam int DEPTH = 2 ** LUT_AW;
    localparam logic [OW-1:0] FS_V = OW'(asin_fs(OW));

    asin_state_t state, state_nxt;

    logic              transfer;
    logic              start_r;
    logic [CH-1:0]     sign_r, sat_r, cap_sign, cap_sat;
    logic [CH*W-1:0]   mag_r, den_r, cap_mag;
    logic [CH*QW-1:0]  q_all;
    logic [CH-1:0]     done_all;
    logic [QW-1:0]     qc;
    logic [LUT_AW-1:0] addr [CH];
    logic [OW-1:0]     val;
    logic [CH*OW-1:0]  angle_nxt;
    logic [OW-1:0]     rom [DEPTH];

    assign in_ready = (state == IDLE);
    assign transfer = in_valid && in_ready;

    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        localparam int V = asin_rom_entry(a, LUT_AW, OW);
        assign rom[a] = OW'(V);
    end

    for (genvar c = 0; c < CH; c++) begin : g_div
        asin_frac_div #(.W(W), .QW(QW)) u_div (
            .clock (clock),
            .rst   (rst),
            .start (start_r),
            .mag   (mag_r[c*W +: W]),
            .den   (den_r[c*W +: W]),
            .done  (done_all[c]),
            .q     (q_all[c*QW +: QW])
        );
    end

    // Magnitude is kept unsigned so the most negative numerator maps to 2^(W-1).
    always_comb begin
        cap_sign = '0;
        cap_mag  = '0;
        cap_sat  = '0;
        for (int c = 0; c < CH; c++) begin
            cap_sign[c] = in_num[c*W + W - 1];
            cap_mag[c*W +: W] = cap_sign[c] ? (~in_num[c*W +: W] + 1'b1) : in_num[c*W +: W];
            cap_sat[c] = (in_den[c*W +: W] == '0) || (cap_mag[c*W +: W] >= in_den[c*W +: W]);
        end
    end

    always_comb begin
        qc        = '0;
        val       = '0;
        angle_nxt = '0;
        for (int c = 0; c < CH; c++) begin
            addr[c] = '0;
        end
        for (int c = 0; c < CH; c++) begin
            qc = q_all[c*QW +: QW];
`ifdef ASIN_ROUND_EN
            addr[c] = (&qc) ? '1 : (qc[QW-1:1] + LUT_AW'(qc[0]));
`else
            addr[c] = qc;
`endif
            if (sat_r[c])
                addr[c] = '1;
            val = sat_r[c] ? FS_V : rom[addr[c]];
            angle_nxt[c*OW +: OW] = sign_r[c] ? (~val + 1'b1) : val;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (transfer)               state_nxt = DIV;
            DIV:  if (&done_all)              state_nxt = LUT;
            LUT:                              state_nxt = HOLD;
            HOLD: if (out_valid && out_ready) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            start_r   <= 1'b0;
            sign_r    <= '0;
            sat_r     <= '0;
            mag_r     <= '0;
            den_r     <= '0;
            out_valid <= 1'b0;
            out_angle <= '0;
            out_sat   <= '0;
        end else begin
            state   <= state_nxt;
            start_r <= transfer;
            if (transfer) begin
                sign_r <= cap_sign;
                sat_r  <= cap_sat;
                mag_r  <= cap_mag;
                den_r  <= in_den;
            end
            if (state == LUT) begin
                out_valid <= 1'b1;
                out_angle <= angle_nxt;
                out_sat   <= sat_r;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_asin_vec_unit.sv
// Directed self-checking bench for asin_vec_unit (W=16, OW=12, CH=2, LUT_AW=10).
// Honours ASIN_ROUND_EN for the expected latency.
module tb_asin_vec_unit;

`ifdef ASIN_ROUND_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 12;
`endif

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_num = '0;
    logic [31:0] in_den = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_angle;
    logic [1:0]  out_sat;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    asin_vec_unit #(.W(16), .OW(12), .CH(2), .LUT_AW(10)) dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_angle (out_angle),
        .out_sat   (out_sat)
    );

    // Caller sits at a negedge with in_ready high; returns at the negedge after the transfer edge.
    task automatic send(input logic [15:0] n0, input logic [15:0] d0,
                        input logic [15:0] n1, input logic [15:0] d1);
        in_num   = {n1, n0};
        in_den   = {d1, d0};
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end
    endtask

    task automatic release_output();
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_num   = {16'd500, 16'd500};
        in_den   = {16'd1000, 16'd1000};
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst      = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0 || out_angle !== 24'd0 || out_sat !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got valid=%b angle=%h sat=%b want 0/000000/00",
                     out_valid, out_angle, out_sat);
        end
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_transfer_ignored: got ready=%b valid=%b want 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_zero();
        int n;
        send(16'd0, 16'd1000, 16'd0, 16'd1000);
        wait_valid(n);
        vectors++;
        if (n !== LAT) begin
            miscompares++;
            $display("[TB] FAIL zero_latency: got %0d want %0d", n, LAT);
        end
        vectors++;
        if (out_angle !== 24'd0 || out_sat !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL zero_result: got angle=%h sat=%b want 000000/00", out_angle, out_sat);
        end
        release_output();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_handshake: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_half();
        int n;
        logic [23:0] expv;
        expv = {-12'sd682, 12'sd682};
        send(16'd500, 16'd1000, -16'sd500, 16'd1000);
        wait_valid(n);
        vectors++;
        if (out_angle !== expv || out_sat !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL half_result: got angle=%h sat=%b want %h/00", out_angle, out_sat, expv);
        end
        release_output();
    endtask

    task automatic test_sat();
        int n;
        logic [23:0] expv;
        expv = {-12'sd2047, 12'sd2047};
        send(16'd1000, 16'd1000, 16'h8000, 16'd0);
        wait_valid(n);
        vectors++;
        if (out_angle !== expv || out_sat !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL sat_result: got angle=%h sat=%b want %h/11", out_angle, out_sat, expv);
        end
        release_output();
        send(16'd0, 16'd0, 16'd0, 16'd7);
        wait_valid(n);
        expv = {12'sd0, 12'sd2047};
        vectors++;
        if (out_angle !== expv || out_sat !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL zero_den_result: got angle=%h sat=%b want %h/01", out_angle, out_sat, expv);
        end
        release_output();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [23:0] expv;
        expv = {12'sd0, 12'sd682};
        send(16'd500, 16'd1000, 16'd0, 16'd1000);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_angle !== expv || out_sat !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL stall_hold[%0d]: got valid=%b ready=%b angle=%h sat=%b want 1/0/%h/00",
                         i, out_valid, in_ready, out_angle, out_sat, expv);
            end
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        send(16'd1023, 16'd1024, -16'sd1023, 16'd1024);
        wait_valid(n);
        expv = {-12'sd1989, 12'sd1989};
        vectors++;
        if (n !== LAT || out_angle !== expv || out_sat !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL b2b_near_one: got lat=%0d angle=%h sat=%b want %0d/%h/00",
                     n, out_angle, out_sat, LAT, expv);
        end
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_high_handshake: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int n;
        logic seen;
        logic [23:0] expv;
        send(16'd1000, 16'd1000, 16'd1000, 16'd1000);
        repeat (3) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_reset_state: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1)
                seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_output: got out_valid seen=%b want 0", seen);
        end
        send(16'd500, 16'd1000, -16'sd500, 16'd1000);
        wait_valid(n);
        expv = {-12'sd682, 12'sd682};
        vectors++;
        if (n !== LAT || out_angle !== expv || out_sat !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL abort_fresh_vector: got lat=%0d angle=%h sat=%b want %0d/%h/00",
                     n, out_angle, out_sat, LAT, expv);
        end
        release_output();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_half();
        test_sat();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
